// File: rtl/mul_add2_prev_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mul_add2_prev_arbiter_pkg : state and owner encodings shared by the slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_add2_prev_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  typedef enum logic {
    OWN_INIT = 1'b0,
    OWN_UPD  = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mul_add2_prev_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_add2_prev_arbiter_if : writer handshakes, consumer release, register port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mul_add2_prev_arbiter_if #(
  parameter int ELEMENT_WIDTH                   = 32,
  parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = 9,
  parameter int COUNT_WIDTH                     = 16
);
  localparam int DW = ELEMENT_WIDTH * NUMBER_OF_EQUATIONS_PER_CLUSTER;

  logic                   init_req;
  logic [DW-1:0]          init_data;
  logic                   init_gnt;
  logic                   upd_req;
  logic [DW-1:0]          upd_data;
  logic                   upd_gnt;
  logic                   rd_done;
  logic                   mem_write_enable;
  logic [DW-1:0]          mem_input_data;
  logic                   prev_valid;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] write_count;

  modport master (
    output init_req, init_data, upd_req, upd_data, rd_done,
    input  init_gnt, upd_gnt, mem_write_enable, mem_input_data,
           prev_valid, busy, write_count
  );

  modport slave (
    input  init_req, init_data, upd_req, upd_data, rd_done,
    output init_gnt, upd_gnt, mem_write_enable, mem_input_data,
           prev_valid, busy, write_count
  );

endinterface

`default_nettype wire

// File: rtl/mul_add2_prev_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2 : two-requester grant select; MUL_ADD2_PREV_RR_ARB_EN selects
// round-robin, otherwise init has fixed priority.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import mul_add2_prev_arbiter_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  req_init,
  input  wire  req_upd,
  input  wire  take,
  output logic sel_init,
  output logic sel_upd
);

`ifdef MUL_ADD2_PREV_RR_ARB_EN
  owner_t last_owner;

  always_ff @(posedge clk) begin
    if (rst)
      last_owner <= OWN_UPD;
    else if (take)
      last_owner <= sel_init ? OWN_INIT : OWN_UPD;
  end

  // On a conflict the requester that did not win last time is served.
  always_comb begin
    sel_init = req_init;
    sel_upd  = req_upd & ~req_init;
    if (req_init && req_upd && last_owner == OWN_INIT) begin
      sel_init = 1'b0;
      sel_upd  = 1'b1;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, take};

  always_comb begin
    sel_init = req_init;
    sel_upd  = req_upd & ~req_init;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mul_add2_prev_arbiter.sv
// ---------------------------------------------------------------------------
// mul_add2_prev_arbiter : shares the result_prev register between init loader
// and mul_add2 update path (MUL_ADD2_PREV_RR_ARB_EN: round-robin).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_add2_prev_arbiter
  import mul_add2_prev_arbiter_pkg::*;
#(
  parameter int ELEMENT_WIDTH                   = 32,
  parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = 9,
  parameter int COUNT_WIDTH                     = 16
) (
  input wire clk,
  input wire rst,
  mul_add2_prev_arbiter_if.slave bus
);
  localparam int DW = ELEMENT_WIDTH * NUMBER_OF_EQUATIONS_PER_CLUSTER;

  state_t                 state_q, state_d;
  logic                   init_gnt_q, init_gnt_d;
  logic                   upd_gnt_q, upd_gnt_d;
  logic                   we_q, we_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   take, sel_init, sel_upd, any_req;

  assign any_req = bus.init_req | bus.upd_req;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_init (bus.init_req),
    .req_upd  (bus.upd_req),
    .take     (take),
    .sel_init (sel_init),
    .sel_upd  (sel_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      init_gnt_q <= 1'b0;
      upd_gnt_q  <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_gnt_q <= init_gnt_d;
      upd_gnt_q  <= upd_gnt_d;
      we_q       <= we_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_gnt_d = 1'b0;
    upd_gnt_d  = 1'b0;
    we_d       = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    count_d    = count_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take = any_req;
      end
      ST_WRITE: begin
        state_d = ST_FULL;
        valid_d = 1'b1;
        count_d = count_q + COUNT_WIDTH'(1);
      end
      ST_FULL: begin
        // Release by the consumer; a waiting request is granted in the same cycle.
        if (bus.rd_done) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          take    = any_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      state_d    = ST_WRITE;
      init_gnt_d = sel_init;
      upd_gnt_d  = sel_upd;
      we_d       = 1'b1;
      data_d     = sel_init ? bus.init_data : bus.upd_data;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.init_gnt         = init_gnt_q;
  assign bus.upd_gnt          = upd_gnt_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_input_data   = data_q;
  assign bus.prev_valid       = valid_q;
  assign bus.busy             = busy_q;
  assign bus.write_count      = count_q;

endmodule

`default_nettype wire
